// File: rtl/midi_pkg.sv
// Shared constants and types for the polyphonic MIDI parser.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHPRESS  = 4'hD;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_THRESH   = 8'hF8;

   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
   localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DATA1 = 3'd1,
      DATA2 = 3'd2,
      SKIP1 = 3'd3,
      SKIP2 = 3'd4,
      SYSEX = 3'd5
   } parse_state_e;

endpackage

// File: rtl/midi_poly_parser_if.sv
// Byte-stream input and voice-bank outputs of the polyphonic MIDI parser.
interface midi_poly_parser_if #(
   parameter int unsigned NUM_VOICES = 4
);
   logic [7:0]              midiByte;
   logic                    midiValid;
   logic [7*NUM_VOICES-1:0] voiceNote;
   logic [7*NUM_VOICES-1:0] voiceVelocity;
   logic [NUM_VOICES-1:0]   voiceGate;
   logic [NUM_VOICES-1:0]   voiceTrig;
   logic [6:0]              envAttack;
   logic [6:0]              envRelease;
   logic [6:0]              filterFreq;

   modport master (
      output midiByte, midiValid,
      input  voiceNote, voiceVelocity, voiceGate, voiceTrig,
             envAttack, envRelease, filterFreq
   );

   modport slave (
      input  midiByte, midiValid,
      output voiceNote, voiceVelocity, voiceGate, voiceTrig,
             envAttack, envRelease, filterFreq
   );
endinterface

// File: rtl/midi_voice_alloc.sv
// Voice slot registers: note-on allocation (match, free, steal), note-off and all-off gating.
module midi_voice_alloc #(
   parameter int unsigned NUM_VOICES = 4
) (
   input  logic                    clk,
   input  logic                    rstN,
   input  logic                    note_on_i,
   input  logic                    note_off_i,
   input  logic                    all_off_i,
   input  logic [6:0]              note_i,
   input  logic [6:0]              vel_i,
   output logic [7*NUM_VOICES-1:0] voice_note_o,
   output logic [7*NUM_VOICES-1:0] voice_vel_o,
   output logic [NUM_VOICES-1:0]   voice_gate_o,
   output logic [NUM_VOICES-1:0]   voice_trig_o
);
   localparam int unsigned SW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [6:0]            vel_q  [NUM_VOICES];
   logic [6:0]            vel_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] gate_q, gate_d;
   logic [NUM_VOICES-1:0] trig_q, trig_d;
   logic [SW-1:0]         steal_q, steal_d;

   logic                  match_hit, free_hit;
   logic [SW-1:0]         match_idx, free_idx, sel;
   logic [NUM_VOICES-1:0] match_vec;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
         end
         gate_q  <= '0;
         trig_q  <= '0;
         steal_q <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            note_q[i] <= note_d[i];
            vel_q[i]  <= vel_d[i];
         end
         gate_q  <= gate_d;
         trig_q  <= trig_d;
         steal_q <= steal_d;
      end
   end

   always_comb begin
      note_d    = note_q;
      vel_d     = vel_q;
      gate_d    = gate_q;
      trig_d    = '0;
      steal_d   = steal_q;
      match_hit = 1'b0;
      match_idx = '0;
      match_vec = '0;
      free_hit  = 1'b0;
      free_idx  = '0;

      // Scan high to low so the lowest matching/free index wins.
      for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
         if (gate_q[i] && (note_q[i] == note_i)) begin
            match_hit    = 1'b1;
            match_idx    = SW'(i);
            match_vec[i] = 1'b1;
         end
         if (!gate_q[i]) begin
            free_hit = 1'b1;
            free_idx = SW'(i);
         end
      end

      sel = match_hit ? match_idx : (free_hit ? free_idx : steal_q);

      if (all_off_i) begin
         gate_d = '0;
      end else if (note_off_i) begin
         gate_d = gate_q & ~match_vec;
      end else if (note_on_i) begin
         if (!match_hit && !free_hit)
            steal_d = (steal_q == SW'(NUM_VOICES - 1)) ? '0 : steal_q + SW'(1);
         for (int i = 0; i < int'(NUM_VOICES); i++) begin
            if (sel == SW'(i)) begin
               note_d[i] = note_i;
               vel_d[i]  = vel_i;
               gate_d[i] = 1'b1;
               trig_d[i] = 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_flat
      assign voice_note_o[7*g +: 7] = note_q[g];
      assign voice_vel_o[7*g +: 7]  = vel_q[g];
   end
   assign voice_gate_o = gate_q;
   assign voice_trig_o = trig_q;

endmodule

// File: rtl/midi_poly_parser.sv
// MIDI byte-stream parser: running status, SysEx/system-common skip, real-time pass-through,
// channel filter, CC latching; drives the voice allocator with one-cycle strobes.
module midi_poly_parser
   import midi_pkg::*;
#(
   parameter int unsigned NUM_VOICES  = 4,
   parameter int unsigned CHAN_FILTER = 0,
   parameter int unsigned CHANNEL     = 0,
   parameter int unsigned CC_ATTACK   = 73,
   parameter int unsigned CC_RELEASE  = 72,
   parameter int unsigned CC_FILTER   = 74
) (
   input logic               clk,
   input logic               rstN,
   midi_poly_parser_if.slave bus
);
   parse_state_e state_q, state_d;
   logic [7:0]   run_q, run_d;
   logic         run_vld_q, run_vld_d;
   logic [6:0]   d1_q, d1_d;
   logic [6:0]   att_q, att_d;
   logic [6:0]   rel_q, rel_d;
   logic [6:0]   filt_q, filt_d;

   logic         fire_c, chan_ok_c;
   logic         note_on_c, note_off_c, all_off_c;
   logic [7:0]   b;

   assign b         = bus.midiByte;
   assign chan_ok_c = (CHAN_FILTER == 0) || (run_q[3:0] == 4'(CHANNEL));

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q   <= IDLE;
         run_q     <= '0;
         run_vld_q <= 1'b0;
         d1_q      <= '0;
         att_q     <= '0;
         rel_q     <= '0;
         filt_q    <= '0;
      end else begin
         state_q   <= state_d;
         run_q     <= run_d;
         run_vld_q <= run_vld_d;
         d1_q      <= d1_d;
         att_q     <= att_d;
         rel_q     <= rel_d;
         filt_q    <= filt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      run_vld_d  = run_vld_q;
      d1_d       = d1_q;
      att_d      = att_q;
      rel_d      = rel_q;
      filt_d     = filt_q;
      fire_c     = 1'b0;
      note_on_c  = 1'b0;
      note_off_c = 1'b0;
      all_off_c  = 1'b0;

      if (bus.midiValid) begin
         if (b >= RT_THRESH) begin
            // real-time bytes leave all state untouched
         end else if (b == SYSEX_START) begin
            state_d   = SYSEX;
            run_vld_d = 1'b0;
         end else if (b[7:4] == 4'hF) begin
            run_vld_d = 1'b0;
            case (b)
               8'hF1, 8'hF3: state_d = SKIP1;
               8'hF2:        state_d = SKIP2;
               SYSEX_END:    state_d = IDLE;
               default:      state_d = IDLE;
            endcase
         end else if (b[7]) begin
            run_d     = b;
            run_vld_d = 1'b1;
            state_d   = DATA1;
         end else begin
            case (state_q)
               SKIP2: state_d = SKIP1;
               SKIP1: state_d = IDLE;
               DATA2: begin
                  fire_c  = 1'b1;
                  state_d = IDLE;
               end
               IDLE, DATA1: begin
                  if (run_vld_q) begin
                     // program change / channel pressure carry no outputs here
                     if (run_q[7:4] == PROG || run_q[7:4] == CHPRESS) begin
                        state_d = IDLE;
                     end else begin
                        d1_d    = b[6:0];
                        state_d = DATA2;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      if (fire_c && chan_ok_c) begin
         case (run_q[7:4])
            NOTE_ON: begin
               if (b[6:0] != 7'd0) note_on_c  = 1'b1;
               else                note_off_c = 1'b1;
            end
            NOTE_OFF: note_off_c = 1'b1;
            CC: begin
               if (d1_q == 7'(CC_ATTACK))  att_d  = b[6:0];
               if (d1_q == 7'(CC_RELEASE)) rel_d  = b[6:0];
               if (d1_q == 7'(CC_FILTER))  filt_d = b[6:0];
               if (d1_q == CC_ALL_NOTES_OFF || d1_q == CC_ALL_SOUND_OFF) all_off_c = 1'b1;
            end
            default: ;
         endcase
      end
   end

   midi_voice_alloc #(.NUM_VOICES(NUM_VOICES)) u_alloc (
      .clk          (clk),
      .rstN         (rstN),
      .note_on_i    (note_on_c),
      .note_off_i   (note_off_c),
      .all_off_i    (all_off_c),
      .note_i       (d1_q),
      .vel_i        (b[6:0]),
      .voice_note_o (bus.voiceNote),
      .voice_vel_o  (bus.voiceVelocity),
      .voice_gate_o (bus.voiceGate),
      .voice_trig_o (bus.voiceTrig)
   );

   assign bus.envAttack  = att_q;
   assign bus.envRelease = rel_q;
   assign bus.filterFreq = filt_q;

endmodule

// File: tb/tb_midi_poly_parser.sv
// Directed bench: an omni 4-voice parser and a channel-2-filtered one share one byte stream.
module tb_midi_poly_parser;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic [7:0] midi_byte = 8'h00;
   logic       midi_valid = 1'b0;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   midi_poly_parser_if #(.NUM_VOICES(4)) bus0 ();
   midi_poly_parser_if #(.NUM_VOICES(4)) bus1 ();

   assign bus0.midiByte  = midi_byte;
   assign bus0.midiValid = midi_valid;
   assign bus1.midiByte  = midi_byte;
   assign bus1.midiValid = midi_valid;

   midi_poly_parser #(.NUM_VOICES(4)) dut0 (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus0)
   );

   midi_poly_parser #(.NUM_VOICES(4), .CHAN_FILTER(1), .CHANNEL(2)) dut1 (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Byte is presented for one full cycle around a rising edge; returns on the next falling edge.
   task automatic send(input logic [7:0] v);
      @(negedge clk);
      midi_byte  = v;
      midi_valid = 1'b1;
      @(negedge clk);
      midi_valid = 1'b0;
   endtask

   // Sends n bytes from v, most significant byte first.
   task automatic send_n(input int n, input logic [63:0] v);
      for (int i = n - 1; i >= 0; i--) send(v[8*i +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstN = 1'b0;
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_gate", 32'(bus0.voiceGate), 32'h0);
      check("rst_trig", 32'(bus0.voiceTrig), 32'h0);
      check("rst_note", 32'(bus0.voiceNote), 32'h0);
      check("rst_vel",  32'(bus0.voiceVelocity), 32'h0);
      check("rst_cc",   32'({bus0.envAttack, bus0.envRelease, bus0.filterFreq}), 32'h0);

      // 1: basic note-on, one-cycle trig
      do_reset();
      send_n(3, {8'h90, 8'h3C, 8'h64});
      check("t1_note0", 32'(bus0.voiceNote[6:0]), 32'h3C);
      check("t1_vel0",  32'(bus0.voiceVelocity[6:0]), 32'h64);
      check("t1_gate",  32'(bus0.voiceGate), 32'h1);
      check("t1_trig",  32'(bus0.voiceTrig), 32'h1);
      check("t1_filt_ch0_gate", 32'(bus1.voiceGate), 32'h0);
      @(negedge clk);
      check("t1_trig_clr", 32'(bus0.voiceTrig), 32'h0);

      // 2: running status, note-on vel 0 as note-off
      do_reset();
      send_n(5, {8'h90, 8'h3C, 8'h64, 8'h40, 8'h50});
      check("t2_gate_two", 32'(bus0.voiceGate), 32'h3);
      check("t2_note1",    32'(bus0.voiceNote[13:7]), 32'h40);
      check("t2_vel1",     32'(bus0.voiceVelocity[13:7]), 32'h50);
      check("t2_trig1",    32'(bus0.voiceTrig), 32'h2);
      send_n(2, {8'h3C, 8'h00});
      check("t2_gate_off", 32'(bus0.voiceGate), 32'h2);
      check("t2_note0_kept", 32'(bus0.voiceNote[6:0]), 32'h3C);
      check("t2_trig_none", 32'(bus0.voiceTrig), 32'h0);

      // 3: voice stealing and retrigger of a held note
      do_reset();
      send_n(7, {8'h90, 8'h30, 8'h01, 8'h31, 8'h01, 8'h32, 8'h01});
      send_n(4, {8'h33, 8'h01, 8'h34, 8'h01});
      check("t3_notes", 32'(bus0.voiceNote), {4'h0, 7'h33, 7'h32, 7'h31, 7'h34});
      check("t3_gate",  32'(bus0.voiceGate), 32'hF);
      check("t3_trig0", 32'(bus0.voiceTrig), 32'h1);
      send_n(2, {8'h35, 8'h01});
      check("t3_steal1", 32'(bus0.voiceNote[13:7]), 32'h35);
      check("t3_trig1",  32'(bus0.voiceTrig), 32'h2);
      send_n(2, {8'h32, 8'h7F});
      check("t3_retrig_vel", 32'(bus0.voiceVelocity[20:14]), 32'h7F);
      check("t3_retrig_trig", 32'(bus0.voiceTrig), 32'h4);
      send_n(2, {8'h36, 8'h01});
      check("t3_steal2", 32'(bus0.voiceNote), {4'h0, 7'h33, 7'h36, 7'h35, 7'h34});

      // 4: SysEx block and real-time byte inside a message
      do_reset();
      send_n(8, {8'hF0, 8'h01, 8'h02, 8'hF7, 8'h90, 8'hF8, 8'h3C, 8'h64});
      check("t4_note0", 32'(bus0.voiceNote[6:0]), 32'h3C);
      check("t4_vel0",  32'(bus0.voiceVelocity[6:0]), 32'h64);
      check("t4_gate",  32'(bus0.voiceGate), 32'h1);
      send_n(4, {8'hF0, 8'hF7, 8'h3D, 8'h64});
      check("t4_runstat_clr", 32'(bus0.voiceGate), 32'h1);
      do_reset();
      send_n(5, {8'hF0, 8'h05, 8'h91, 8'h41, 8'h22});
      check("t4_sysex_term", 32'(bus0.voiceNote[6:0]), 32'h41);
      do_reset();
      send_n(8, {8'h90, 8'h3C, 8'h64, 8'hF2, 8'h3D, 8'h64, 8'h3E, 8'h64});
      check("t4_songpos_skip", 32'(bus0.voiceGate), 32'h1);
      send_n(6, {8'h90, 8'h3C, 8'h64, 8'hC0, 8'h05, 8'h3D});
      check("t4_prog_1byte", 32'(bus0.voiceGate), 32'h1);

      // 5: channel filter
      do_reset();
      send_n(3, {8'h91, 8'h3C, 8'h64});
      check("t5_ch1_filtered", 32'(bus1.voiceGate), 32'h0);
      check("t5_ch1_omni", 32'(bus0.voiceGate), 32'h1);
      send_n(3, {8'h92, 8'h3C, 8'h64});
      check("t5_ch2_gate", 32'(bus1.voiceGate), 32'h1);
      check("t5_ch2_note", 32'(bus1.voiceNote[6:0]), 32'h3C);
      check("t5_omni_retrig", 32'(bus0.voiceGate), 32'h1);

      // 6: CCs, all-off, note-off, abort, async reset
      do_reset();
      send_n(3, {8'hB0, 8'h4A, 8'h55});
      check("t6_filter", 32'(bus0.filterFreq), 32'h55);
      send_n(6, {8'hB0, 8'h49, 8'h11, 8'hB0, 8'h48, 8'h22});
      check("t6_attack",  32'(bus0.envAttack), 32'h11);
      check("t6_release", 32'(bus0.envRelease), 32'h22);
      send_n(6, {8'h90, 8'h3C, 8'h64, 8'h90, 8'h3D, 8'h64});
      check("t6_gate_pre", 32'(bus0.voiceGate), 32'h3);
      send_n(3, {8'hB0, 8'h7B, 8'h00});
      check("t6_all_notes_off", 32'(bus0.voiceGate), 32'h0);
      check("t6_note_kept", 32'(bus0.voiceNote[13:7]), 32'h3D);
      send_n(6, {8'h90, 8'h40, 8'h10, 8'hB0, 8'h78, 8'h00});
      check("t6_all_sound_off", 32'(bus0.voiceGate), 32'h0);
      send_n(6, {8'h90, 8'h50, 8'h10, 8'h80, 8'h51, 8'h00});
      check("t6_unmatched_off", 32'(bus0.voiceGate), 32'h1);
      send_n(3, {8'h80, 8'h50, 8'h00});
      check("t6_note_off", 32'(bus0.voiceGate), 32'h0);
      send_n(5, {8'h90, 8'h3C, 8'hB0, 8'h4A, 8'h33});
      check("t6_abort_gate", 32'(bus0.voiceGate), 32'h0);
      check("t6_abort_cc", 32'(bus0.filterFreq), 32'h33);
      send_n(4, {8'h90, 8'h3C, 8'h64, 8'h40});
      #2 rstN = 1'b0;
      #1;
      check("t6_arst_gate", 32'(bus0.voiceGate), 32'h0);
      check("t6_arst_note", 32'(bus0.voiceNote), 32'h0);
      check("t6_arst_cc",   32'({bus0.envAttack, bus0.envRelease, bus0.filterFreq}), 32'h0);
      @(negedge clk);
      rstN = 1'b1;
      send(8'h64);
      check("t6_arst_runstat", 32'(bus0.voiceGate), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
